clk_div_param: RTL and testbench

Parametrised integer clock divider. It is the successor to the team's fixed 8-bit divider. It generates a divided clock of period N reference cycles, with a selectable high-phase length for odd ratios. Ratio changes are glitch-free and take effect only at a period boundary. An optional stop-at-period-end mode prevents runt pulses. A one-cycle period-start tick and an active flag are provided for downstream enables, such as UART/SPI baud generation.

---
 rtl/clk_div_param.sv | 89 ++++++++
 tb/tb_clk_div_param.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_param.sv
// rtl/clk_div_param.sv - parametrised integer clock divider with boundary-aligned ratio changes
module clk_div_param #(
    parameter int RATIO_W       = 8,
    parameter bit ODD_HIGH_LONG = 1'b1,
    parameter bit STOP_AT_END   = 1'b1
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic [RATIO_W-1:0] i_div_ratio,
    output logic               o_div_clk,
    output logic               o_tick,
    output logic               o_active
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [RATIO_W-1:0] r_cnt;
    logic [RATIO_W-1:0] r_act;
    logic [RATIO_W-1:0] r_h_act;
    logic               r_div_clk;
    logic               r_tick;
    logic               r_active;

    logic               w_ratio_ok;
    logic               w_at_end;
    logic               w_load;
    logic               w_go_idle;
    logic [RATIO_W:0]   w_n_ext;
    logic [RATIO_W:0]   w_inc_ext;
    logic [RATIO_W:0]   w_h_ext;
    logic [RATIO_W-1:0] w_cnt_inc;

    // High length is formed one bit wider so (N+1)/2 cannot wrap at the maximum ratio.
    always_comb begin
        w_n_ext   = {1'b0, i_div_ratio};
        w_inc_ext = '0;
        if (ODD_HIGH_LONG && i_div_ratio[0]) begin
            w_inc_ext = {{RATIO_W{1'b0}}, 1'b1};
        end
        w_h_ext = (w_n_ext + w_inc_ext) >> 1;
    end

    assign w_ratio_ok = (i_div_ratio >= {{(RATIO_W-1){1'b0}}, 1'b1} + {{(RATIO_W-1){1'b0}}, 1'b1});
    assign w_at_end   = (r_cnt == r_act - {{(RATIO_W-1){1'b0}}, 1'b1});
    assign w_cnt_inc  = r_cnt + {{(RATIO_W-1){1'b0}}, 1'b1};
    assign w_load     = i_clk_en && w_ratio_ok && ((r_state == ST_IDLE) || w_at_end);

    // Without a load, IDLE stays idle, a boundary ends the run, and an early stop
    // only cuts the period short when stopping at the period end is disabled.
    assign w_go_idle  = (r_state == ST_IDLE) || w_at_end || (!i_clk_en && !STOP_AT_END);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_act     <= '0;
            r_h_act   <= '0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_active  <= 1'b0;
        end else if (w_load) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_act     <= i_div_ratio;
            r_h_act   <= w_h_ext[RATIO_W-1:0];
            r_div_clk <= (w_h_ext != '0);
            r_tick    <= 1'b1;
            r_active  <= 1'b1;
        end else if (w_go_idle) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_inc;
            r_div_clk <= (w_cnt_inc < r_h_act);
            r_tick    <= 1'b0;
        end
    end

    assign o_div_clk = r_div_clk;
    assign o_tick    = r_tick;
    assign o_active  = r_active;

endmodule

// File: tb/tb_clk_div_param.sv
// tb/tb_clk_div_param.sv - randomized and directed check of clk_div_param against a period model
module tb_clk_div_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] ratio;
    logic       a_div, a_tick, a_act;
    logic       b_div, b_tick, b_act;

    int n_tests = 0;
    int n_fail  = 0;

    // Model per divider: whether running, active ratio, position inside the period.
    bit m_run [2];
    int m_n   [2];
    int m_pos [2];

    always #5 clk = ~clk;

    clk_div_param #(.RATIO_W(8), .ODD_HIGH_LONG(1'b1), .STOP_AT_END(1'b1)) dut_a (
        .i_ref_clk   (clk),
        .i_rst_n     (rst_n),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .o_div_clk   (a_div),
        .o_tick      (a_tick),
        .o_active    (a_act)
    );

    clk_div_param #(.RATIO_W(8), .ODD_HIGH_LONG(1'b0), .STOP_AT_END(1'b0)) dut_b (
        .i_ref_clk   (clk),
        .i_rst_n     (rst_n),
        .i_clk_en    (en),
        .i_div_ratio (ratio),
        .o_div_clk   (b_div),
        .o_tick      (b_tick),
        .o_active    (b_act)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int high_len(input int n, input bit long_odd);
        if (n % 2 == 0) return n / 2;
        return long_odd ? (n + 1) / 2 : (n - 1) / 2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0;
            m_n[k]   = 0;
            m_pos[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input bit stop_at_end);
        if (!m_run[k] || m_pos[k] == m_n[k] - 1) begin
            if (en && ratio >= 2) begin
                m_run[k] = 1'b1;
                m_n[k]   = ratio;
                m_pos[k] = 0;
            end else begin
                m_run[k] = 1'b0;
                m_pos[k] = 0;
            end
        end else if (!en && !stop_at_end) begin
            m_run[k] = 1'b0;
            m_pos[k] = 0;
        end else begin
            m_pos[k]++;
        end
    endtask

    task automatic compare_all(input string tag);
        bit ediv [2];
        bit etick[2];
        for (int k = 0; k < 2; k++) begin
            ediv[k]  = m_run[k] && (m_pos[k] < high_len(m_n[k], k == 0));
            etick[k] = m_run[k] && (m_pos[k] == 0);
        end
        check({tag, ".a.div"},  {31'd0, a_div},  {31'd0, ediv[0]});
        check({tag, ".a.tick"}, {31'd0, a_tick}, {31'd0, etick[0]});
        check({tag, ".a.act"},  {31'd0, a_act},  {31'd0, m_run[0]});
        check({tag, ".b.div"},  {31'd0, b_div},  {31'd0, ediv[1]});
        check({tag, ".b.tick"}, {31'd0, b_tick}, {31'd0, etick[1]});
        check({tag, ".b.act"},  {31'd0, b_act},  {31'd0, m_run[1]});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge(0, 1'b1);
        model_edge(1, 1'b0);
        #1;
        compare_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
    task automatic reset_pulse();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int  high_cnt;
        rst_n = 1'b0;
        en    = 1'b0;
        ratio = 8'd0;
        model_reset();
        #12;
        compare_all("reset");
        rst_n = 1'b1;

        run("idle_dis", 3);

        en = 1'b1; ratio = 8'd4;
        run("n4", 20);

        ratio = 8'd5;
        run("n5", 7);
        reset_pulse();
        run("n5_after_rst", 12);

        ratio = 8'd6;
        for (int i = 0; i < 30; i++) begin
            cycle("n6_align");
            if (m_run[0] && m_n[0] == 6 && m_pos[0] == 2) break;
        end
        check("n6_aligned", {31'd0, (m_n[0] == 6 && m_pos[0] == 2)}, 32'd1);
        ratio = 8'd3;
        run("n6_to_3", 15);

        ratio = 8'd8;
        for (int i = 0; i < 30; i++) begin
            cycle("n8_align");
            if (m_run[0] && m_n[0] == 8 && m_pos[0] == 1) break;
        end
        check("n8_aligned", {31'd0, (m_n[0] == 8 && m_pos[0] == 1)}, 32'd1);
        en = 1'b0;
        run("n8_stop", 10);
        check("n8_stopped", {31'd0, a_act}, 32'd0);

        en = 1'b1; ratio = 8'd0;
        run("ratio0", 5);
        ratio = 8'd1;
        run("ratio1", 5);

        ratio = 8'd255;
        cycle("n255_load");
        high_cnt = a_div ? 1 : 0;
        for (int i = 1; i < 255; i++) begin
            cycle("n255");
            if (a_div) high_cnt++;
        end
        check("n255_high", high_cnt, 32'd128);
        cycle("n255_wrap");
        check("n255_tick", {31'd0, a_tick}, 32'd1);

        ratio = 8'd3;
        for (int i = 0; i < 300; i++) begin
            cycle("to1_align");
            if (m_run[0] && m_n[0] == 3 && m_pos[0] == 2) break;
        end
        ratio = 8'd1;
        cycle("to1_switch");
        check("to1_idle", {31'd0, a_act}, 32'd0);
        run("to1_hold", 3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 9) == 0)
                ratio = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 499) == 0) reset_pulse();
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
